// File: rtl/pwm_pkg.sv
// Shared constants and arithmetic for the PWM duty-level blocks.
package pwm_pkg;
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_MAX_LEVEL   = 10;
    localparam int DEF_STEP        = 1;
    localparam int DEF_PRESCALE    = 1;
    localparam int DEF_SYNC_STAGES = 2;

    // 32-bit intermediate so level+step can exceed the level width without wrapping.
    function automatic logic [31:0] sat_step(
        input logic [31:0] level,
        input logic [31:0] step,
        input logic [31:0] max_level,
        input logic        down
    );
        logic [31:0] res;
        if (down)
            res = (level < step) ? 32'd0 : level - step;
        else
            res = (level + step > max_level) ? max_level : level + step;
        return res;
    endfunction
endpackage

// File: rtl/btn_edge_sync.sv
// Synchroniser chain plus history flop; emits a one-cycle pulse per rising edge.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_press = r_sync[SYNC_STAGES-1] & ~r_hist;
endmodule

// File: rtl/updown_level_pwm.sv
// Button-driven saturating duty level with a period-aligned PWM output.
module updown_level_pwm
    import pwm_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int STEP        = DEF_STEP,
    parameter int PRESCALE    = DEF_PRESCALE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_c,
    input  logic             reset_n_c,
    input  logic             up_c,
    input  logic             down_c,
    input  logic             hold_c,
    input  logic             load_c,
    input  logic [WIDTH-1:0] load_value_c,
    output logic [WIDTH-1:0] level_c,
    output logic             pwm_c,
    output logic             at_max_c,
    output logic             at_min_c
);
    localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0] L_LAST = WIDTH'(MAX_LEVEL - 1);
    localparam int               PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    L_PRE_LAST = PW'(PRESCALE - 1);

    logic             w_up;
    logic             w_dn;
    logic [WIDTH-1:0] r_level;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_up_sync (
        .i_clk   (clk_c),
        .i_rst_n (reset_n_c),
        .i_btn   (up_c),
        .o_press (w_up)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dn_sync (
        .i_clk   (clk_c),
        .i_rst_n (reset_n_c),
        .i_btn   (down_c),
        .o_press (w_dn)
    );

    // Load beats hold; hold and simultaneous presses drop the press entirely.
    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c)
            r_level <= '0;
        else if (load_c)
            r_level <= (load_value_c > L_MAX) ? L_MAX : load_value_c;
        else if (!hold_c && (w_up ^ w_dn))
            r_level <= WIDTH'(sat_step(32'(r_level), 32'(STEP), 32'(MAX_LEVEL), w_dn));
    end

    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_active;
    logic             r_started;
    logic             r_pwm;
    logic             w_tick;
    logic             w_cnt_last;
    logic             w_load_act;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_act_nxt;

    assign w_tick     = (r_presc == L_PRE_LAST);
    assign w_cnt_last = (r_cnt == L_LAST);
    assign w_load_act = w_tick && (!r_started || w_cnt_last);
    assign w_cnt_nxt  = !w_tick ? r_cnt : (w_cnt_last ? '0 : r_cnt + 1'b1);
    assign w_act_nxt  = w_load_act ? r_level : r_active;

    // Active level only moves at period start, so duty changes never produce runts.
    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            r_presc   <= '0;
            r_cnt     <= '0;
            r_active  <= '0;
            r_started <= 1'b0;
            r_pwm     <= 1'b0;
        end else begin
            r_presc   <= w_tick ? '0 : r_presc + 1'b1;
            r_cnt     <= w_cnt_nxt;
            r_active  <= w_act_nxt;
            r_started <= r_started | w_tick;
            r_pwm     <= (w_cnt_nxt < w_act_nxt);
        end
    end

    assign level_c  = r_level;
    assign pwm_c    = r_pwm;
    assign at_max_c = (r_level == L_MAX);
    assign at_min_c = (r_level == '0);
endmodule

// File: tb/tb_updown_level_pwm.sv
// Bench: default, STEP=3 and PRESCALE=2 instances on shared stimulus.
module tb_updown_level_pwm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up = 1'b0, down = 1'b0, hold = 1'b0, load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] a_lvl, b_lvl, c_lvl;
    logic       a_pwm, b_pwm, c_pwm;
    logic       a_max, b_max, c_max, a_min, b_min, c_min;

    always #5 clk = ~clk;

    updown_level_pwm u_a (
        .clk_c(clk), .reset_n_c(rst_n), .up_c(up), .down_c(down), .hold_c(hold),
        .load_c(load), .load_value_c(load_value), .level_c(a_lvl), .pwm_c(a_pwm),
        .at_max_c(a_max), .at_min_c(a_min));

    updown_level_pwm #(.STEP(3)) u_b (
        .clk_c(clk), .reset_n_c(rst_n), .up_c(up), .down_c(down), .hold_c(hold),
        .load_c(load), .load_value_c(load_value), .level_c(b_lvl), .pwm_c(b_pwm),
        .at_max_c(b_max), .at_min_c(b_min));

    updown_level_pwm #(.PRESCALE(2)) u_c (
        .clk_c(clk), .reset_n_c(rst_n), .up_c(up), .down_c(down), .hold_c(hold),
        .load_c(load), .load_value_c(load_value), .level_c(c_lvl), .pwm_c(c_pwm),
        .at_max_c(c_max), .at_min_c(c_min));

    int n_tests = 0;
    int n_fail  = 0;
    int ma = 0;
    int mb = 0;

    typedef struct { int a; int b; } exp_t;
    exp_t sb[$];

    typedef struct {
        logic up; logic dn; logic hold; logic load; int lv; int exp;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model(input int lvl, input int step, input logic u, input logic d);
        if (u && !d) return (lvl + step > 10) ? 10 : lvl + step;
        if (d && !u) return (lvl < step) ? 0 : lvl - step;
        return lvl;
    endfunction

    // Raw press on the negedge before edge 1; level must move exactly on edge 3.
    task automatic press(input logic u, input logic d);
        exp_t e;
        int   old_a;
        old_a = ma;
        ma = model(ma, 1, u, d);
        mb = model(mb, 3, u, d);
        e.a = ma; e.b = mb;
        sb.push_back(e);
        @(negedge clk); up = u; down = d;
        @(posedge clk); #1;
        @(negedge clk); up = 1'b0; down = 1'b0;
        @(posedge clk); #1;
        check("press_early_a", a_lvl, old_a);
        @(posedge clk); #1;
        e = sb.pop_front();
        check("press_a", a_lvl, e.a);
        check("press_b", b_lvl, e.b);
        repeat (7) @(posedge clk);
    endtask

    task automatic do_load(input int v);
        int e;
        e = (v > 10) ? 10 : v;
        @(negedge clk); load = 1'b1; load_value = 4'(v);
        @(posedge clk); #1;
        check("load_a", a_lvl, e);
        check("load_b", b_lvl, e);
        check("load_c", c_lvl, e);
        @(negedge clk); load = 1'b0;
        ma = e; mb = e;
    endtask

    // Skip any partial high run on u_c, then stop on the negedge of a fresh rise.
    task automatic sync_rise();
        int n;
        n = 0;
        while (c_pwm && n < 200) begin @(negedge clk); n++; end
        while (!c_pwm && n < 400) begin @(negedge clk); n++; end
        check("pwm_rise", int'(c_pwm), 1);
    endtask

    // Called at a rise; measures the high run and the following low run of u_c.
    task automatic measure(input int load_at, input int lv, output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (c_pwm && hi < 200) begin
            hi++;
            if (hi == load_at) begin load_value = 4'(lv); load = 1'b1; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        while (!c_pwm && lo < 200) begin lo++; @(negedge clk); end
    endtask

    initial begin
        int hi, lo, ha, hc, n;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5,  5};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 0,  5};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  5};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 0,  5};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 15, 10};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 2,  2};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  1};

        repeat (3) @(negedge clk);
        check("rst_level_a", a_lvl, 0);
        check("rst_pwm_a", a_pwm, 0);
        check("rst_min_a", a_min, 1);
        check("rst_max_a", a_max, 0);
        check("rst_level_c", c_lvl, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 12; i++) press(1'b1, 1'b0);
        check("sat_max_a", a_max, 1);
        check("sat_level_a", a_lvl, 10);

        do_load(0);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
        check("step_min_b", b_min, 1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hold = tbl[i].hold; up = tbl[i].up; down = tbl[i].dn;
            load = tbl[i].load; load_value = 4'(tbl[i].lv);
            @(negedge clk); up = 1'b0; down = 1'b0; load = 1'b0;
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_a", i), a_lvl, tbl[i].exp);
            hold = 1'b0;
        end

        do_load(3);
        repeat (50) @(negedge clk);
        sync_rise();
        measure(0, 0, hi, lo);
        check("duty3_hi", hi, 6);
        check("duty3_lo", lo, 14);
        measure(2, 7, hi, lo);
        check("midload_cur_hi", hi, 6);
        check("midload_cur_lo", lo, 14);
        measure(0, 0, hi, lo);
        check("duty7_hi", hi, 14);
        check("duty7_lo", lo, 6);

        do_load(0);
        repeat (45) @(negedge clk);
        ha = 0; hc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); ha += int'(a_pwm); hc += int'(c_pwm);
        end
        check("lvl0_a_highs", ha, 0);
        check("lvl0_c_highs", hc, 0);

        do_load(10);
        repeat (45) @(negedge clk);
        ha = 0; hc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); ha += int'(a_pwm); hc += int'(c_pwm);
        end
        check("lvl10_a_highs", ha, 60);
        check("lvl10_c_highs", hc, 60);

        do_load(7);
        repeat (25) @(negedge clk);
        n = 0;
        while (!a_pwm && n < 50) begin @(negedge clk); n++; end
        check("rst_pre_pwm_a", a_pwm, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm_a", a_pwm, 0);
        check("async_rst_level_a", a_lvl, 0);
        check("async_rst_min_a", a_min, 1);
        check("async_rst_max_a", a_max, 0);
        up = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("held_up_a", a_lvl, 1);
        check("held_up_b", b_lvl, 3);
        repeat (10) @(negedge clk);
        check("held_up_once_a", a_lvl, 1);
        up = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
